// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: FSM state encoding and default
// access timeout.
package mem_stage_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/dm_wait_counter.sv
// Wait-cycle counter for an outstanding data-memory access; saturates at TIMEOUT-1
// and flags that terminal count.
module dm_wait_counter
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != TC_VAL)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with req/ack data-memory port and the MEM/WB register; stalls upstream
// while an access is outstanding. Optional alignment check: MISALIGN_CHK_EN.
module mem_wb_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] result_in,
    input  logic [31:0] busB_in,
    input  logic [4:0]  Rw_in,
    input  logic        MemtoReg_in,
    input  logic        RegWr_in,
    input  logic        MemWr_in,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic [31:0] wb_data,
    output logic [4:0]  Rw_out,
    output logic        RegWr_out,
    output logic        stall_out,
    output logic        bus_err,
    output logic        misalign_err
);

    mem_state_t  state;
    logic        mem_op;
    logic        misaligned;
    logic        tc;
    logic [4:0]  held_rw;
    logic        held_regwr;
    logic        held_load;

    assign mem_op = MemtoReg_in | MemWr_in;

`ifdef MISALIGN_CHK_EN
    assign misaligned = mem_op & (|result_in[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    dm_wait_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == IDLE),
        .enable ((state == ACCESS) && !dm_ack),
        .tc     (tc)
    );

    // An ack on the terminal-count cycle counts as completion, so it releases the stall too.
    assign stall_out = !rst &&
                       (((state == IDLE) && mem_op && !misaligned) ||
                        ((state == ACCESS) && !dm_ack && !tc));

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            dm_req       <= 1'b0;
            dm_we        <= 1'b0;
            dm_addr      <= '0;
            dm_wdata     <= '0;
            wb_data      <= '0;
            Rw_out       <= '0;
            RegWr_out    <= 1'b0;
            bus_err      <= 1'b0;
            misalign_err <= 1'b0;
            held_rw      <= '0;
            held_regwr   <= 1'b0;
            held_load    <= 1'b0;
        end else begin
            bus_err      <= 1'b0;
            misalign_err <= 1'b0;
            if (state == IDLE) begin
                if (misaligned) begin
                    RegWr_out    <= 1'b0;
                    misalign_err <= 1'b1;
                end else if (mem_op) begin
                    dm_req     <= 1'b1;
                    dm_we      <= MemWr_in;
                    dm_addr    <= result_in;
                    dm_wdata   <= busB_in;
                    held_rw    <= Rw_in;
                    held_regwr <= RegWr_in;
                    held_load  <= MemtoReg_in & ~MemWr_in;
                    RegWr_out  <= 1'b0;
                    state      <= ACCESS;
                end else begin
                    wb_data   <= result_in;
                    Rw_out    <= Rw_in;
                    RegWr_out <= RegWr_in;
                end
            end else begin
                if (dm_ack) begin
                    dm_req    <= 1'b0;
                    dm_we     <= 1'b0;
                    wb_data   <= held_load ? dm_rdata : dm_addr;
                    Rw_out    <= held_rw;
                    RegWr_out <= held_regwr;
                    state     <= IDLE;
                end else if (tc) begin
                    dm_req    <= 1'b0;
                    dm_we     <= 1'b0;
                    bus_err   <= 1'b1;
                    RegWr_out <= 1'b0;
                    state     <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed cases plus random ops against a transaction-level
// model of latency, write-back value and error pulses.
module tb_mem_wb_stage;

    localparam int TIMEOUT = 4;

    logic        clk;
    logic        rst;
    logic [31:0] result_in;
    logic [31:0] busB_in;
    logic [4:0]  Rw_in;
    logic        MemtoReg_in;
    logic        RegWr_in;
    logic        MemWr_in;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic [31:0] wb_data;
    logic [4:0]  Rw_out;
    logic        RegWr_out;
    logic        stall_out;
    logic        bus_err;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    // reference write-back register contents
    logic [31:0] m_wb;
    logic [4:0]  m_rw;

    mem_wb_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .result_in    (result_in),
        .busB_in      (busB_in),
        .Rw_in        (Rw_in),
        .MemtoReg_in  (MemtoReg_in),
        .RegWr_in     (RegWr_in),
        .MemWr_in     (MemWr_in),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_ack       (dm_ack),
        .dm_rdata     (dm_rdata),
        .wb_data      (wb_data),
        .Rw_out       (Rw_out),
        .RegWr_out    (RegWr_out),
        .stall_out    (stall_out),
        .bus_err      (bus_err),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One pipeline op from the EX/MEM side; ack arrives after 'delay' wait cycles.
    task automatic do_op(input logic ld, input logic st, input logic rwe, input logic [4:0] rw,
                         input logic [31:0] addr, input logic [31:0] bdata,
                         input logic [31:0] rdata, input int delay);
        int   k;
        int   reqs;
        int   stalls;
        int   berrs;
        logic stable_ok;
        logic mis;
        logic completes;
        MemtoReg_in = ld;
        MemWr_in    = st;
        RegWr_in    = rwe;
        Rw_in       = rw;
        result_in   = addr;
        busB_in     = bdata;
        dm_ack      = 1'($urandom_range(0, 1));
        dm_rdata    = $urandom;
        mis = 1'b0;
`ifdef MISALIGN_CHK_EN
        mis = (addr[1:0] != 2'b00);
`endif
        #1;
        stalls = int'(stall_out);
        if (!(ld | st) || mis) begin
            check("stall_nomem", stall_out, 0);
            @(negedge clk); @(posedge clk);
            check("req_nomem", dm_req, 0);
            if (!(ld | st)) begin
                m_wb = addr;
                m_rw = rw;
                check("regwr_nomem", RegWr_out, rwe);
            end else begin
                check("regwr_mis", RegWr_out, 0);
            end
            check("misalign_pulse", misalign_err, mis);
            check("wb_nomem", wb_data, m_wb);
            check("rw_nomem", Rw_out, m_rw);
        end else begin
            @(negedge clk); @(posedge clk);
            k = 0; reqs = 0; berrs = 0; stable_ok = 1'b1;
            while (dm_req && k < TIMEOUT + 4) begin
                reqs++;
                if (dm_we !== st || dm_addr !== addr || dm_wdata !== bdata ||
                    RegWr_out !== 1'b0 || bus_err !== 1'b0)
                    stable_ok = 1'b0;
                dm_ack   = (k == delay);
                dm_rdata = (k == delay) ? rdata : $urandom;
                #1;
                stalls += int'(stall_out);
                @(negedge clk); @(posedge clk);
                dm_ack = 1'b0;
                k++;
                berrs += int'(bus_err);
            end
            completes = (delay < TIMEOUT);
            check("req_cycles", reqs, completes ? delay + 1 : TIMEOUT);
            check("stall_cycles", stalls, completes ? delay + 1 : TIMEOUT);
            check("dm_stable", stable_ok, 1);
            check("bus_err_count", berrs, completes ? 0 : 1);
            check("req_dropped", dm_req, 0);
            if (completes) begin
                m_wb = (ld && !st) ? rdata : addr;
                m_rw = rw;
            end
            check("wb_mem", wb_data, m_wb);
            check("rw_mem", Rw_out, m_rw);
            check("regwr_mem", RegWr_out, completes ? rwe : 1'b0);
            check("misalign_quiet", misalign_err, 0);
        end
        MemtoReg_in = 1'b0;
        MemWr_in    = 1'b0;
        RegWr_in    = 1'b0;
        Rw_in       = 5'($urandom);
        result_in   = $urandom;
        @(negedge clk); @(posedge clk);
        m_wb = result_in;
        m_rw = Rw_in;
        check("bubble_regwr", RegWr_out, 0);
        check("bubble_bus_err", bus_err, 0);
        check("bubble_misalign", misalign_err, 0);
        check("bubble_wb", wb_data, m_wb);
    endtask

    initial begin
        rst         = 1'b1;
        MemtoReg_in = 1'b1;
        MemWr_in    = 1'b0;
        RegWr_in    = 1'b1;
        Rw_in       = 5'd3;
        result_in   = 32'h40;
        busB_in     = 32'h0;
        dm_ack      = 1'b0;
        dm_rdata    = 32'h0;
        m_wb        = 32'h0;
        m_rw        = 5'd0;
        #1;
        check("rst_wb", wb_data, 0);
        check("rst_rw", Rw_out, 0);
        check("rst_regwr", RegWr_out, 0);
        check("rst_req", dm_req, 0);
        check("rst_we", dm_we, 0);
        check("rst_addr", dm_addr, 0);
        check("rst_wdata", dm_wdata, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_misalign", misalign_err, 0);
        check("rst_stall", stall_out, 0);
        @(posedge clk); @(posedge clk);
        MemtoReg_in = 1'b0;
        RegWr_in    = 1'b0;
        rst         = 1'b0;

        do_op(1'b0, 1'b0, 1'b1, 5'd5,  32'h1234, 32'h0,    32'h0,        0);
        do_op(1'b1, 1'b0, 1'b1, 5'd9,  32'h40,   32'h0,    32'hDEADBEEF, 3);
        do_op(1'b0, 1'b1, 1'b0, 5'd2,  32'h80,   32'hCAFE, 32'h0,        2);
        do_op(1'b1, 1'b1, 1'b0, 5'd4,  32'h84,   32'hBEEF, 32'h5555,     0);
        do_op(1'b1, 1'b0, 1'b1, 5'd11, 32'h200,  32'h0,    32'h12345678, 1000);
        do_op(1'b1, 1'b0, 1'b1, 5'd12, 32'h42,   32'h0,    32'hA5A5A5A5, 1);

        // reset in the second ACCESS cycle
        MemtoReg_in = 1'b1;
        RegWr_in    = 1'b1;
        Rw_in       = 5'd7;
        result_in   = 32'h100;
        dm_ack      = 1'b0;
        @(negedge clk); @(posedge clk);
        @(negedge clk); @(posedge clk);
        check("pre_rst_req", dm_req, 1);
        rst = 1'b1;
        #1;
        check("midrst_req", dm_req, 0);
        check("midrst_addr", dm_addr, 0);
        check("midrst_wb", wb_data, 0);
        check("midrst_stall", stall_out, 0);
        check("midrst_regwr", RegWr_out, 0);
        MemtoReg_in = 1'b0;
        RegWr_in    = 1'b0;
        @(negedge clk); @(posedge clk);
        rst  = 1'b0;
        m_wb = 32'h0;
        m_rw = 5'd0;
        do_op(1'b0, 1'b0, 1'b1, 5'd6, 32'h777, 32'h0, 32'h0, 0);

        for (int i = 0; i < 30; i++) begin
            logic [1:0]  kind;
            logic [31:0] a;
            kind = 2'($urandom_range(0, 3));
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            do_op(kind == 2'd1 || kind == 2'd3, kind == 2'd2 || kind == 2'd3,
                  1'($urandom_range(0, 1)), 5'($urandom), a, $urandom, $urandom,
                  $urandom_range(0, TIMEOUT + 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage of the 5-stage pipeline. It consumes the EX/MEM pipeline register outputs and drives a request/acknowledge data-memory port. It also registers the write-back values that feed the register file, acting as the MEM/WB register. While a memory access is outstanding it stalls everything upstream, including EX/MEM, and presents a bubble to WB.

## Interface
- TIMEOUT, 16: maximum ACCESS cycles without `dm_ack` before the access is abandoned; legal range 2..255.
- clk  in  1  pipeline clock; all state updates on negedge clk, like the other pipeline registers.
- rst  in  1  reset; asynchronous, active-high.
- result_in  in  32  ALU result from EX/MEM; this is the memory address for loads and stores.
- busB_in  in  32  store data from EX/MEM.
- Rw_in  in  5  destination register.
- MemtoReg_in  in  1  load.
- RegWr_in  in  1  register write enable.
- MemWr_in  in  1  store.
- dm_req  out  1  memory request, held until ack or timeout.
- dm_we  out  1  1 = write.
- dm_addr  out  32  access address.
- dm_wdata  out  32  write data.
- dm_ack  in  1  memory done; sampled only in ACCESS.
- dm_rdata  in  32  read data, valid with `dm_ack`.
- wb_data  out  32  write-back data.
- Rw_out  out  5  write-back register.
- RegWr_out  out  1  write-back enable.
- stall_out  out  1  combinational; freeze PC, IF/ID, ID/EX and EX/MEM.
- bus_err  out  1  one-cycle pulse on timeout.
- misalign_err  out  1  one-cycle pulse on a misaligned access; tied 0 without the macro.

## Operation
- States: IDLE, ACCESS.
- A memory op is `MemtoReg_in | MemWr_in`. When both are set the op is a store: `dm_we=1` and `wb_data` gets `result_in`.
- **IDLE, non-memory op:**
  - Edge action: `wb_data<=result_in`, `Rw_out<=Rw_in`, `RegWr_out<=RegWr_in`.
  - Stay in IDLE; `stall_out=0`.
- **IDLE, memory op:**
  - `stall_out=1`.
  - Edge action: capture the op into holding registers; `dm_req<=1`, `dm_we<=MemWr_in`, `dm_addr<=result_in`, `dm_wdata<=busB_in`.
  - Also on that edge: `RegWr_out<=0` (bubble), counter `<=0`, go to ACCESS.
- **ACCESS, `dm_ack=0`:**
  - `stall_out=1`; counter increments; `dm_*` outputs stay stable.
  - WB outputs hold, with `RegWr_out=0`.
- **ACCESS, `dm_ack=1`:**
  - `stall_out=0`, so EX/MEM advances on the same edge.
  - Edge action: `dm_req<=0`, `dm_we<=0`.
  - `wb_data` gets `dm_rdata` for a load, or the held address for a store.
  - `Rw_out<=held Rw`, `RegWr_out<=held RegWr`; go to IDLE.
- **ACCESS, counter == TIMEOUT-1 and no ack:**
  - `stall_out=0`.
  - Edge action: `dm_req<=0`, `bus_err<=1` for one cycle, `RegWr_out<=0`, go to IDLE.
- `dm_ack` is ignored outside ACCESS. An ack on the timeout cycle wins and is treated as a normal completion.
- Counter width is `$clog2(TIMEOUT)`; it saturates and never wraps.

## Timing
- Non-memory op: one edge to WB.
- Memory op: 2 edges when `dm_ack` is high in the first ACCESS cycle, plus one edge per wait cycle. `dm_req` stays high for at most TIMEOUT cycles.
- Reset values: all outputs 0 (`wb_data`, `Rw_out`, `RegWr_out`, `dm_req`, `dm_we`, `dm_addr`, `dm_wdata`, `bus_err`, `misalign_err`). State is IDLE and the counter is 0.
- `stall_out` is forced to 0 while `rst` is high.
- Reset mid-ACCESS: `dm_req` drops immediately (asynchronous) and the access is discarded; the memory must tolerate an abandoned request.

## Configuration
- `MISALIGN_CHK_EN` defined:
  - A memory op with `result_in[1:0]!=0` does not enter ACCESS, and `dm_req` stays 0.
  - `stall_out=0`; on the edge, `RegWr_out<=0` and `misalign_err<=1` for one cycle.
- Undefined: the address is passed through unchecked and `misalign_err` is constant 0.

## Structure
- Shared package `mem_stage_pkg`: the state enum (IDLE, ACCESS) and the default TIMEOUT constant.
- One sub-module, `dm_wait_counter`: clear, enable, and a terminal-count flag at TIMEOUT-1, reset asynchronously by `rst`.

## Test plan
- Non-memory op, `result_in=0x1234`, `Rw_in=5`, `RegWr_in=1` -> next edge `wb_data=0x1234`, `Rw_out=5`, `RegWr_out=1`, no stall.
- Load at address 0x40 with `dm_ack` after 3 wait cycles and `dm_rdata=0xDEADBEEF` -> `stall_out` high for 4 cycles; then `wb_data=0xDEADBEEF` and `RegWr_out=1` exactly once.
- Store at 0x80 with `busB_in=0xCAFE` -> `dm_we=1` and `dm_wdata=0xCAFE` stable until ack; `RegWr_out=0` throughout.
- No ack with TIMEOUT=4 -> `dm_req` high for exactly 4 cycles; one-cycle `bus_err`; no register write; stall releases.
- `rst` asserted in the second ACCESS cycle -> `dm_req` and all outputs 0 immediately; IDLE after release.
- With `MISALIGN_CHK_EN`, load at 0x42 -> no `dm_req`, `misalign_err` pulse, `RegWr_out=0`.
